cla_add_arbiter: RTL and testbench
==================================

# cla_add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead adder between two requesters. Each accepted request is registered, driven onto the external adder in the following cycle, and the sum and carry-out are registered and returned to the owning requester. Per-requester carry registers let each requester chain multi-word additions through the single shared adder.

## Interface
- WIDTH, 32, operand and sum width; must match the attached adder.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i: requester i has an operation pending.
- req_ready  output  2  bit i: requester i's operation is accepted this cycle (one-hot or zero).
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_a, req1_b  input  WIDTH  requester 1 operands.
- req_chain  input  2  bit i: carry-in comes from requester i's saved carry instead of the default.
- req_sub  input  2  bit i: subtract (a − b); used only with CLA_ARB_SUB_EN.
- add_a, add_b  output  WIDTH  operands driven to the adder.
- add_cin  output  1  carry-in driven to the adder.
- add_s  input  WIDTH  adder sum, combinational from add_a, add_b and add_cin.
- add_cout  input  1  adder carry-out.
- resp_valid  output  2  bit i: the response on resp_sum/resp_cout belongs to requester i.
- resp_sum  output  WIDTH  registered sum.
- resp_cout  output  1  registered carry-out.

## Operation
- Arbitration is combinational from req_valid and last_grant:
  - Only one bit of req_valid set: that requester is granted.
  - Both set: the requester other than last_grant is granted.
  - last_grant updates on every accept.
- Accept: req_ready[i] & req_valid[i] at a rising edge loads the execute register with a, b, chain, sub and id = i; exec_valid is set.
- If nothing is accepted at an edge, exec_valid clears.
- Execute cycle (exec_valid = 1): add_a = a_q, add_b = b_q, add_cin = chain_q ? carry_q[id_q] : 0.
- At the end of the execute cycle:
  - resp_sum <= add_s, resp_cout <= add_cout.
  - resp_valid <= one-hot(id_q).
  - carry_q[id_q] <= add_cout.
- Every operation overwrites its requester's carry_q, whether or not it is chained. The other requester's carry_q is never touched.
- When exec_valid = 0: add_a, add_b and add_cin are held at 0, and resp_valid clears at the next edge.
- There is no response backpressure. Each requester must take resp_* in the cycle resp_valid[i] is high.
- Reset state: req_ready = 0 combinationally while rst_n is low, exec_valid = 0, resp_valid = 0, resp_sum = 0, resp_cout = 0, carry_q = 0, last_grant = 1 (requester 0 wins the first tie).
- Reset asserted mid-operation: in-flight execute and response contents are discarded and all state returns to reset values immediately.

## Timing
- Latency: accept at edge k, execute during cycle k→k+1, resp_valid high from edge k+1 to edge k+2.
- Throughput: one operation per cycle across both requesters.
- Under continuous contention, grants strictly alternate 0,1,0,1 starting with 0 after reset.
- Back-to-back chained operations from the same requester need no stall. carry_q is written at the end of execute N and read during execute N+1.
- Interleaved chains stay independent. A requester-1 operation between two requester-0 chained words does not disturb carry_q[0].
- Adder path: add_* must settle within one clock period. The adder's own clk pin is unused by this block.

## Configuration
- CLA_ARB_SUB_EN defined:
  - req_sub[i] = 1 drives add_b = ~b_q.
  - add_cin = chain_q ? carry_q[id_q] : 1.
  - resp_cout = 1 means no borrow. Chained subtraction uses the saved carry as not-borrow.
- CLA_ARB_SUB_EN undefined: req_sub is ignored, treated as 0. Add-only path; no inverter or cin mux leg is synthesised.

## Test plan
- Reset, then req_valid=01, a=5, b=7 -> req_ready=01 same cycle; resp_valid=01, resp_sum=12, resp_cout=0 two edges later.
- Both valid for 4 cycles -> grants 0,1,0,1; responses follow in the same order, one per cycle.
- Requester 0 does 64-bit add 0x00000001_FFFFFFFF + 0x00000000_00000001 (low word chain=0, then high word chain=1) -> low resp_sum=0, cout=1; high resp_sum=0x00000002.
- Requester 0 low word (cout=1), then requester 1 op with a=b=0 (cout=0), then requester 0 high word chained with a=b=0 -> requester 0 high resp_sum=1.
- With CLA_ARB_SUB_EN: a=3, b=5, sub=1 -> resp_sum=0xFFFFFFFE, resp_cout=0. Without the macro, the same stimulus -> resp_sum=8.
- Assert rst_n low during an execute cycle -> resp_valid stays 0, carry_q=0; the first op after release with chain=1, a=b=0 returns 0.

Source files
------------

// File: rtl/cla_add_arbiter.sv
// Round-robin sharing of one external 32-bit carry-lookahead adder between two requesters.
// Optional subtract support is built in when the macro CLA_ARB_SUB_EN is defined.
module cla_add_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req_chain,
    input  logic [1:0]       req_sub,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic [1:0]       resp_valid,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout
);

    logic [1:0]       grant;
    logic             last_grant;
    logic             accept;
    logic             sel;
    logic             exec_valid;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             chain_q;
    logic             id_q;
    logic [1:0]       carry_q;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = rst_n ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel       = req_ready[1];

`ifdef CLA_ARB_SUB_EN
    logic sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= req_sub[sel];
        end
    end
`else
    logic unused_sub;
    assign unused_sub = ^req_sub;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_valid <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            chain_q    <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            exec_valid <= accept;
            if (accept) begin
                last_grant <= sel;
                a_q        <= sel ? req1_a : req0_a;
                b_q        <= sel ? req1_b : req0_b;
                chain_q    <= req_chain[sel];
                id_q       <= sel;
            end
        end
    end

    // Adder inputs idle at zero; an unchained subtract uses cin=1 to form a - b.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (exec_valid) begin
            add_a = a_q;
`ifdef CLA_ARB_SUB_EN
            add_b   = sub_q ? ~b_q : b_q;
            add_cin = chain_q ? carry_q[id_q] : sub_q;
`else
            add_b   = b_q;
            add_cin = chain_q & carry_q[id_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 2'b00;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            carry_q    <= 2'b00;
        end else if (exec_valid) begin
            resp_valid       <= id_q ? 2'b10 : 2'b01;
            resp_sum         <= add_s;
            resp_cout        <= add_cout;
            carry_q[id_q]    <= add_cout;
        end else begin
            resp_valid <= 2'b00;
        end
    end

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Scoreboard bench for cla_add_arbiter with a behavioural adder attached to add_*.
// Expected responses are modelled at accept time and compared when resp_valid fires.
module tb_cla_add_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]   req_chain = 2'b00;
    logic [1:0]   req_sub = 2'b00;
    logic [W-1:0] add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic [1:0]   resp_valid;
    logic [W-1:0] resp_sum;
    logic         resp_cout;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]   vld;
        logic [W-1:0] sum;
        logic         cout;
    } resp_t;

    resp_t      sb[$];
    logic       tb_last;
    logic [1:0] tb_carry;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    cla_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req_chain(req_chain), .req_sub(req_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .resp_valid(resp_valid), .resp_sum(resp_sum), .resp_cout(resp_cout)
    );

    // Response monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid != 2'b00) begin
            resp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got valid=%b sum=%h, expected no response", resp_valid, resp_sum);
            end else begin
                e = sb.pop_front();
                if (resp_valid !== e.vld || resp_sum !== e.sum || resp_cout !== e.cout) begin
                    errors++;
                    $display("FAIL resp: got valid=%b sum=%h cout=%b, expected valid=%b sum=%h cout=%b",
                             resp_valid, resp_sum, resp_cout, e.vld, e.sum, e.cout);
                end
            end
        end
    end

    task automatic model_reset();
        tb_last  = 1'b1;
        tb_carry = 2'b00;
        sb.delete();
    endtask

    // Called just after a rising edge; drives one cycle of requests and checks the grant.
    task automatic drive_op(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input logic [1:0] chain, input logic [1:0] sub);
        logic [1:0]   eg;
        logic         id;
        logic         se;
        logic         cin;
        logic [W-1:0] a, b;
        logic [W:0]   full;
        req_valid = v; req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req_chain = chain; req_sub = sub;
        case (v)
            2'b01:   eg = 2'b01;
            2'b10:   eg = 2'b10;
            2'b11:   eg = tb_last ? 2'b01 : 2'b10;
            default: eg = 2'b00;
        endcase
        @(negedge clk);
        checks++;
        if (req_ready !== eg) begin
            errors++;
            $display("FAIL grant: got req_ready=%b, expected %b", req_ready, eg);
        end
        if (eg != 2'b00) begin
            id = eg[1];
            tb_last = id;
`ifdef CLA_ARB_SUB_EN
            se = sub[id];
`else
            se = 1'b0;
`endif
            a = id ? a1 : a0;
            b = id ? b1 : b0;
            if (se) b = ~b;
            cin = chain[id] ? tb_carry[id] : se;
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            tb_carry[id] = full[W];
            sb.push_back('{vld: eg, sum: full[W-1:0], cout: full[W]});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00; req_chain = 2'b00; req_sub = 2'b00;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        #12;
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_sum !== '0 || resp_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rv=%b sum=%h cout=%b, expected all zero",
                     req_ready, resp_valid, resp_sum, resp_cout);
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_adder: got a=%h b=%h cin=%b, expected zero", add_a, add_b, add_cin);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        drive_op(2'b11, 32'd10, 32'd1, 32'd20, 32'd2, 2'b00, 2'b00);
        drive_op(2'b11, 32'd30, 32'd3, 32'd40, 32'd4, 2'b00, 2'b00);
        drive_op(2'b11, 32'hFFFF_0000, 32'h0001_0000, 32'd50, 32'd5, 2'b00, 2'b00);
        drive_op(2'b11, 32'd60, 32'd6, 32'h8000_0000, 32'h8000_0001, 2'b00, 2'b00);
        idle(3);
    endtask

    task automatic test_basic();
        drive_op(2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00);
        checks++;
        if (add_a !== 32'd5 || add_b !== 32'd7 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL exec_operands: got a=%h b=%h cin=%b, expected 5 7 0", add_a, add_b, add_cin);
        end
        idle(1);
        checks++;
        if (add_a !== '0) begin
            errors++;
            $display("FAIL idle_operands: got add_a=%h, expected 0", add_a);
        end
        drive_op(2'b10, 32'd0, 32'd0, 32'h1234_5678, 32'h1111_1111, 2'b00, 2'b00);
        idle(3);
    endtask

    task automatic test_chain64();
        drive_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 2'b00, 2'b00);
        drive_op(2'b01, 32'h0000_0001, 32'h0000_0000, 32'd0, 32'd0, 2'b01, 2'b00);
        idle(3);
    endtask

    task automatic test_interleave();
        drive_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 2'b00, 2'b00);
        drive_op(2'b10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        drive_op(2'b01, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01, 2'b00);
        drive_op(2'b10, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10, 2'b00);
        idle(3);
    endtask

    task automatic test_sub();
        drive_op(2'b10, 32'd0, 32'd0, 32'd3, 32'd5, 2'b00, 2'b10);
        drive_op(2'b10, 32'd0, 32'd0, 32'd9, 32'd4, 2'b00, 2'b10);
        drive_op(2'b10, 32'd0, 32'd0, 32'd1, 32'd1, 2'b10, 2'b10);
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 2'b00, 2'b00);
        drive_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 2'b00, 2'b00);
        req_valid = 2'b00;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00 || add_a !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rv=%b add_a=%h, expected 0 0", resp_valid, add_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got rv=%b, expected 00", resp_valid);
        end
        @(posedge clk); #1;
        drive_op(2'b01, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01, 2'b00);
        drive_op(2'b11, 32'd0, 32'd0, 32'd0, 32'd0, 2'b11, 2'b00);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_basic();
        test_chain64();
        test_interleave();
        test_sub();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses still outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
